// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter, the I/D requesters and the external memory port.
// The master view is the arbiter; the slave view is everything around it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic [DW-1:0] i_rdata;
  logic          i_valid;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic [DW-1:0]   d_rdata;
  logic            d_valid;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  logic stall_fetch_mem;
  logic stall_pipe_mem;
  logic timeout_err;

  modport master (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ack, mem_rdata,
    output i_rdata, i_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_fetch_mem, stall_pipe_mem, timeout_err
  );

  modport slave (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ack, mem_rdata,
    input  i_rdata, i_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_fetch_mem, stall_pipe_mem, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-fetch and load/store, D side first,
// with flush-drop of wrong-path fetches and a per-access timeout watchdog.
//
// state  | meaning
// IDLE   | no access in flight; grant D, else unflushed I
// I_BUSY | fetch issued, waiting for mem_ack or timeout
// D_BUSY | load/store issued, waiting for mem_ack or timeout
// RESP   | one-cycle completion pulse to the owner
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic          drop;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_plus;
  logic          busy, ack, expire, done, grant_d, grant_i, drop_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.d_req)                      state_nxt = D_BUSY;
        else if (bus.i_req && !bus.i_flush) state_nxt = I_BUSY;
      end
      I_BUSY, D_BUSY: if (done) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == I_BUSY) || (state == D_BUSY);
    grant_d  = (state == IDLE) && bus.d_req;
    grant_i  = (state == IDLE) && !bus.d_req && bus.i_req && !bus.i_flush;
    ack      = busy && bus.mem_ack;
    cnt_plus = {1'b0, cnt} + 1'b1;
    // Expiry fires on the TIMEOUT-th ack-less BUSY cycle; a same-cycle ack wins.
    expire   = busy && !bus.mem_ack && (TIMEOUT != 0) &&
               (cnt_plus == (CW+1)'(TIMEOUT));
    done     = ack || expire;
    drop_now = drop || ((state == I_BUSY) && bus.i_flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_be      <= '0;
      bus.i_rdata     <= '0;
      bus.i_valid     <= 1'b0;
      bus.d_rdata     <= '0;
      bus.d_valid     <= 1'b0;
      bus.timeout_err <= 1'b0;
      drop            <= 1'b0;
      cnt             <= '0;
    end else begin
      bus.i_valid <= 1'b0;
      bus.d_valid <= 1'b0;

      if (grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_be    <= bus.d_be;
      end else if (grant_i) begin
        bus.mem_req  <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.i_addr;
        bus.mem_be   <= '1;
      end

      if (done) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
        if (state == D_BUSY) begin
          bus.d_rdata <= ack ? bus.mem_rdata : '0;
          bus.d_valid <= 1'b1;
        end else if (!drop_now) begin
          bus.i_rdata <= ack ? bus.mem_rdata : '0;
          bus.i_valid <= 1'b1;
        end
      end

      if (expire) bus.timeout_err <= 1'b1;

      if (state == RESP)                          drop <= 1'b0;
      else if ((state == I_BUSY) && bus.i_flush)  drop <= 1'b1;

      if (grant_d || grant_i)                     cnt <= '0;
      else if (busy && !bus.mem_ack && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign bus.stall_fetch_mem = bus.i_req && !bus.i_valid;
  assign bus.stall_pipe_mem  = bus.d_req && !bus.d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-stepped stimulus with a read-data
// scoreboard that is filled at issue time and drained on each valid pulse.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  logic [31:0] exp_i, exp_d;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: every valid pulse must match the oldest queued value.
  always @(negedge clk) begin
    if (bus.i_valid === 1'b1) begin
      checks++;
      if (i_q.size() == 0) begin
        failures++;
        $error("FAIL i_sb_unexpected: observed=i_valid expected=none");
      end else begin
        exp_i = i_q.pop_front();
        assert (bus.i_rdata === exp_i) else begin
          failures++;
          $error("FAIL i_sb_rdata: observed=%h expected=%h", bus.i_rdata, exp_i);
        end
      end
    end
    if (bus.d_valid === 1'b1) begin
      checks++;
      if (d_q.size() == 0) begin
        failures++;
        $error("FAIL d_sb_unexpected: observed=d_valid expected=none");
      end else begin
        exp_d = d_q.pop_front();
        assert (bus.d_rdata === exp_d) else begin
          failures++;
          $error("FAIL d_sb_rdata: observed=%h expected=%h", bus.d_rdata, exp_d);
        end
      end
    end
  end

  int prev_cyc;

  initial begin
    rst_n = 1'b0;
    bus.i_req = 0; bus.i_addr = '0; bus.i_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    step(); step();

    chk("rst_mem_req",   bus.mem_req, 0);
    chk("rst_mem_we",    bus.mem_we, 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_be",    bus.mem_be, 0);
    chk("rst_i_valid",   bus.i_valid, 0);
    chk("rst_d_valid",   bus.d_valid, 0);
    chk("rst_i_rdata",   bus.i_rdata, 0);
    chk("rst_d_rdata",   bus.d_rdata, 0);
    chk("rst_timeout",   bus.timeout_err, 0);
    #3 rst_n = 1'b1;
    step();

    // Basic fetch, ack on second BUSY cycle
    bus.i_req = 1; bus.i_addr = 32'h0040_0000; i_q.push_back(32'h2402_0005); #1;
    chk("t1_stall_idle", bus.stall_fetch_mem, 1);
    chk("t1_req_idle",   bus.mem_req, 0);
    step();
    chk("t1_req_b1",  bus.mem_req, 1);
    chk("t1_addr",    bus.mem_addr, 32'h0040_0000);
    chk("t1_we",      bus.mem_we, 0);
    chk("t1_be",      bus.mem_be, 32'hf);
    chk("t1_stall_b1", bus.stall_fetch_mem, 1);
    step();
    chk("t1_req_b2", bus.mem_req, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h2402_0005; #1;
    chk("t1_stall_b2", bus.stall_fetch_mem, 1);
    step();
    bus.mem_ack = 0;
    chk("t1_req_resp",   bus.mem_req, 0);
    chk("t1_i_valid",    bus.i_valid, 1);
    chk("t1_i_rdata",    bus.i_rdata, 32'h2402_0005);
    chk("t1_stall_resp", bus.stall_fetch_mem, 0);
    bus.i_req = 0;
    step();
    chk("t1_i_valid_off", bus.i_valid, 0);

    // Simultaneous I and D: D store goes first
    bus.i_req = 1; bus.i_addr = 32'h0040_0004;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1000_0010;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b1111;
    d_q.push_back(32'h1111_2222);
    step();
    chk("t2_req",   bus.mem_req, 1);
    chk("t2_we",    bus.mem_we, 1);
    chk("t2_addr",  bus.mem_addr, 32'h1000_0010);
    chk("t2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t2_be",    bus.mem_be, 32'hf);
    chk("t2_stall_f_busy", bus.stall_fetch_mem, 1);
    chk("t2_stall_p_busy", bus.stall_pipe_mem, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_ack = 0;
    chk("t2_d_valid",      bus.d_valid, 1);
    chk("t2_i_valid",      bus.i_valid, 0);
    chk("t2_stall_f_resp", bus.stall_fetch_mem, 1);
    chk("t2_stall_p_resp", bus.stall_pipe_mem, 0);
    chk("t2_we_cleared",   bus.mem_we, 0);
    bus.d_req = 0; bus.d_we = 0;
    step();
    chk("t2_idle_req",    bus.mem_req, 0);
    chk("t2_stall_idle",  bus.stall_fetch_mem, 1);
    i_q.push_back(32'h8C42_0000);
    step();
    chk("t2_i_req",  bus.mem_req, 1);
    chk("t2_i_addr", bus.mem_addr, 32'h0040_0004);
    chk("t2_i_we",   bus.mem_we, 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h8C42_0000;
    step();
    bus.mem_ack = 0;
    chk("t2_i_valid_resp", bus.i_valid, 1);
    bus.i_req = 0;
    step();

    // Flush one cycle before ack drops the fetch
    bus.i_req = 1; bus.i_addr = 32'h0040_0008;
    step();
    step();
    bus.i_flush = 1;
    step();
    bus.i_flush = 0; bus.mem_ack = 1; bus.mem_rdata = 32'hBAD0_BAD0;
    step();
    bus.mem_ack = 0;
    chk("t3_req_resp",  bus.mem_req, 0);
    chk("t3_no_valid",  bus.i_valid, 0);
    chk("t3_rdata_old", bus.i_rdata, 32'h8C42_0000);
    bus.i_req = 0;
    step();
    chk("t3_idle_valid", bus.i_valid, 0);
    bus.i_req = 1; bus.i_flush = 1; bus.i_addr = 32'h0040_0100;
    step();
    chk("t3_flush_ignored", bus.mem_req, 0);
    bus.i_flush = 0; i_q.push_back(32'h0000_0013);
    step();
    chk("t3_new_req",  bus.mem_req, 1);
    chk("t3_new_addr", bus.mem_addr, 32'h0040_0100);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0013;
    step();
    bus.mem_ack = 0;
    chk("t3_new_valid", bus.i_valid, 1);
    bus.i_req = 0;
    step();

    // Timeout on a D load with no ack
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000_0020; bus.d_be = 4'b0011;
    bus.mem_rdata = 32'hFFFF_FFFF; d_q.push_back(32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_req_busy", bus.mem_req, 1);
      chk("t4_err_busy", bus.timeout_err, 0);
    end
    step();
    chk("t4_req_dropped", bus.mem_req, 0);
    chk("t4_d_valid",     bus.d_valid, 1);
    chk("t4_d_rdata",     bus.d_rdata, 0);
    chk("t4_err_set",     bus.timeout_err, 1);
    bus.d_req = 0;
    step();
    bus.d_req = 1; bus.d_addr = 32'h1000_0024; d_q.push_back(32'hCAFE_0001);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_0001;
    step();
    bus.mem_ack = 0;
    chk("t4_ok_valid",  bus.d_valid, 1);
    chk("t4_err_stuck", bus.timeout_err, 1);
    bus.d_req = 0;
    step();

    // Asynchronous reset mid D_BUSY, then reissue; ack on the expiry cycle wins
    bus.d_req = 1; bus.d_addr = 32'h1000_0030;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req_async", bus.mem_req, 0);
    chk("t5_dv_async",  bus.d_valid, 0);
    chk("t5_err_async", bus.timeout_err, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    d_q.push_back(32'h55AA_55AA);
    step();
    chk("t5_reissue_req",  bus.mem_req, 1);
    chk("t5_reissue_addr", bus.mem_addr, 32'h1000_0030);
    step();
    step();
    step();
    chk("t5_req_b4", bus.mem_req, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h55AA_55AA;
    step();
    bus.mem_ack = 0;
    chk("t5_d_valid", bus.d_valid, 1);
    chk("t5_no_err",  bus.timeout_err, 0);
    bus.d_req = 0;
    step();

    // Stray ack in IDLE, then back-to-back fetches
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0;
    chk("t6_stray_req", bus.mem_req, 0);
    chk("t6_stray_iv",  bus.i_valid, 0);
    chk("t6_stray_dv",  bus.d_valid, 0);
    step();
    chk("t6_still_idle", bus.mem_req, 0);
    prev_cyc = 0;
    bus.i_req = 1;
    for (int k = 0; k < 3; k++) begin
      bus.i_addr = 32'h0040_0200 + 32'(4 * k);
      i_q.push_back(32'hA000_0000 + 32'(k));
      step();
      chk("t6_req",  bus.mem_req, 1);
      chk("t6_addr", bus.mem_addr, 32'h0040_0200 + 32'(4 * k));
      bus.mem_ack = 1; bus.mem_rdata = 32'hA000_0000 + 32'(k);
      step();
      bus.mem_ack = 0;
      chk("t6_valid", bus.i_valid, 1);
      if (k > 0) chk("t6_spacing", 32'(cyc - prev_cyc), 3);
      prev_cyc = cyc;
      if (k == 2) bus.i_req = 0;
      step();
    end

    step();
    chk("sb_i_empty", 32'(i_q.size()), 0);
    chk("sb_d_empty", 32'(d_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
